// File: rtl/panel_input_ctrl_if.sv
// panel_input_ctrl_if: raw panel buttons in, alarm-clock control strobes and levels out
interface panel_input_ctrl_if;
    logic btn_tset, btn_aset, btn_min, btn_hrs, btn_day, btn_aon;
    logic Pulse, Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon;
    modport master (
        output btn_tset, btn_aset, btn_min, btn_hrs, btn_day, btn_aon,
        input  Pulse, Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon
    );
    modport slave (
        input  btn_tset, btn_aset, btn_min, btn_hrs, btn_day, btn_aon,
        output Pulse, Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon
    );
endinterface

// File: rtl/panel_input_ctrl.sv
// panel_input_ctrl: 1 Hz prescaler, button sync/debounce, alarm toggle and auto-repeat advance strobes
module panel_input_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DB_CYCLES  = 500_000,
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 10_000_000
) (
    input logic clk,
    input logic rst,
    panel_input_ctrl_if.slave io
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int RW = $clog2((REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER) + 1);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RPT} adv_e;
    logic [TW-1:0] tick_q;
    logic [5:0] raw, s1_q, s2_q, lvl_q, flip;
    logic [3:0] rise;
    logic [2:0] fall, stb;
    logic aon_q, mode;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_q <= '0;
        else tick_q <= (tick_q == TW'(TICK_DIV - 1)) ? '0 : tick_q + 1'b1;
    end
    // bit order: 0 tset, 1 aset, 2 min, 3 hrs, 4 day, 5 aon
    assign raw = {io.btn_aon, io.btn_day, io.btn_hrs, io.btn_min, io.btn_aset, io.btn_tset};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            lvl_q <= '0;
            aon_q <= 1'b0;
        end else begin
            s1_q  <= raw;
            s2_q  <= s1_q;
            lvl_q <= lvl_q ^ flip;
            aon_q <= aon_q ^ rise[3];
        end
    end
    for (genvar b = 0; b < 6; b++) begin : g_db
        logic [DW-1:0] cnt_q;
        assign flip[b] = (s2_q[b] != lvl_q[b]) && (cnt_q == DW'(DB_CYCLES - 1));
        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q <= '0;
            else cnt_q <= (s2_q[b] == lvl_q[b] || flip[b]) ? '0 : cnt_q + 1'b1;
        end
    end
    assign rise = flip[5:2] & ~lvl_q[5:2];
    assign fall = flip[4:2] & lvl_q[4:2];
    assign mode = lvl_q[0] | lvl_q[1];
    // FSMs keep running while set mode is off; only their strobes are gated
    for (genvar a = 0; a < 3; a++) begin : g_adv
        adv_e st_q, st_d;
        logic [RW-1:0] cnt_q, cnt_d;
        logic stb_q, stb_d;
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            stb_d = 1'b0;
            if (fall[a]) st_d = S_IDLE;
            else if (st_q == S_IDLE) begin
                if (rise[a]) begin
                    stb_d = 1'b1;
                    cnt_d = RW'(REPEAT_DLY - 1);
                    st_d  = S_WAIT;
                end
            end else if (cnt_q == '0) begin
                stb_d = 1'b1;
                cnt_d = RW'(REPEAT_PER - 1);
                st_d  = S_RPT;
            end else cnt_d = cnt_q - 1'b1;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q  <= S_IDLE;
                cnt_q <= '0;
                stb_q <= 1'b0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                stb_q <= stb_d;
            end
        end
        assign stb[a] = stb_q;
    end
    assign io.Pulse    = tick_q == TW'(TICK_DIV - 1);
    assign io.Timeset  = lvl_q[0];
    assign io.Alarmset = lvl_q[1] & ~lvl_q[0];
    assign io.Minadv   = stb[0] & mode;
    assign io.Hrsadv   = stb[1] & mode;
    assign io.Dayadv   = stb[2] & mode;
    assign io.Alarmon  = aon_q;
endmodule

// File: tb/tb_panel_input_ctrl.sv
// tb_panel_input_ctrl: random and directed panel stimulus scored against a window/hold-time reference model
module tb_panel_input_ctrl;
    localparam int TD = 10, DB = 4, RD = 20, RP = 5;
    localparam logic [5:0] TSET = 6'b000001, ASET = 6'b000010, MIN = 6'b000100,
                           HRS = 6'b001000, DAY = 6'b010000, AON = 6'b100000;
    logic clk = 1'b0, rst = 1'b1;
    panel_input_ctrl_if pif();
    panel_input_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB), .REPEAT_DLY(RD), .REPEAT_PER(RP)) dut (
        .clk(clk), .rst(rst), .io(pif)
    );
    always #5 clk = ~clk;
    typedef struct {time t; logic [6:0] v;} rec_t;
    rec_t expq[$];
    rec_t e;
    int checks = 0, errors = 0;
    logic [5:0] rawh[$], syn[$];
    logic [5:0] lvl;
    logic aon;
    int hold[3];
    int nedge;
    function automatic logic [6:0] dut_out();
        return {pif.Pulse, pif.Timeset, pif.Alarmset, pif.Minadv, pif.Hrsadv, pif.Dayadv, pif.Alarmon};
    endfunction
    task automatic model_reset();
        rawh  = {6'b0, 6'b0};
        syn   = {};
        lvl   = '0;
        aon   = 1'b0;
        hold  = '{-1, -1, -1};
        nedge = 0;
    endtask
    // one clock edge: a button level flips once its last DB synced samples all disagree with it;
    // an advance strobes at hold time 0, RD, RD+RP, RD+2RP, ...
    task automatic model_step(input logic [5:0] r);
        logic [5:0] s, flip, rise, fall;
        logic [2:0] stb;
        logic mode, pulse;
        bit all_diff;
        s = rawh[0];
        rawh.push_back(r);
        void'(rawh.pop_front());
        syn.push_back(s);
        if (syn.size() > DB) void'(syn.pop_front());
        for (int b = 0; b < 6; b++) begin
            all_diff = (syn.size() == DB);
            foreach (syn[i]) if (syn[i][b] == lvl[b]) all_diff = 0;
            flip[b] = all_diff;
        end
        rise = flip & ~lvl;
        fall = flip & lvl;
        lvl  = lvl ^ flip;
        aon  = aon ^ rise[5];
        for (int a = 0; a < 3; a++) begin
            if (fall[a+2]) begin
                hold[a] = -1;
                stb[a]  = 1'b0;
            end else if (rise[a+2]) begin
                hold[a] = 0;
                stb[a]  = 1'b1;
            end else if (hold[a] >= 0) begin
                hold[a]++;
                stb[a] = (hold[a] >= RD) && ((hold[a] - RD) % RP == 0);
            end else stb[a] = 1'b0;
        end
        mode  = lvl[0] | lvl[1];
        nedge++;
        pulse = (nedge % TD == TD - 1);
        expq.push_back('{$time + 4, {pulse, lvl[0], lvl[1] & ~lvl[0], stb[0] & mode, stb[1] & mode, stb[2] & mode, aon}});
    endtask
    task automatic tick(input logic [5:0] r);
        {pif.btn_aon, pif.btn_day, pif.btn_hrs, pif.btn_min, pif.btn_aset, pif.btn_tset} = r;
        @(posedge clk);
        #1;
        model_step(r);
    endtask
    task automatic hold_for(input logic [5:0] r, input int n);
        repeat (n) tick(r);
    endtask
    task automatic do_reset(input int n);
        rst  = 1'b1;
        expq = {};
        #1;
        checks++;
        if (dut_out() !== 7'b0) begin
            errors++;
            $display("FAIL reset_immediate got %b expected 0000000", dut_out());
        end
        repeat (n) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask
    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].t < $time) begin
            checks++;
            errors++;
            $display("FAIL missed_sample t=%0t expected %b", expq[0].t, expq[0].v);
            void'(expq.pop_front());
        end
        if (expq.size() > 0 && expq[0].t == $time) begin
            e = expq.pop_front();
            checks++;
            if (dut_out() !== e.v) begin
                errors++;
                $display("FAIL outputs t=%0t got %b expected %b (Pulse,Tset,Aset,Min,Hrs,Day,Aon)", $time, dut_out(), e.v);
            end
        end else if (rst) begin
            checks++;
            if (dut_out() !== 7'b0) begin
                errors++;
                $display("FAIL reset_hold t=%0t got %b expected 0000000", $time, dut_out());
            end
        end
    end
    initial begin
        logic [5:0] r;
        {pif.btn_aon, pif.btn_day, pif.btn_hrs, pif.btn_min, pif.btn_aset, pif.btn_tset} = 6'b0;
        do_reset(2);
        hold_for(6'b0, 35);
        repeat (2) begin
            hold_for(TSET, 3);
            hold_for(6'b0, 2);
        end
        hold_for(TSET, 12);
        hold_for(TSET | MIN, 50);
        hold_for(TSET, 10);
        hold_for(TSET | ASET, 10);
        hold_for(ASET, 12);
        hold_for(6'b0, 10);
        repeat (2) begin
            hold_for(AON, 10);
            hold_for(6'b0, 10);
        end
        hold_for(HRS, 40);
        hold_for(6'b0, 10);
        hold_for(AON, 10);
        hold_for(6'b0, 8);
        hold_for(TSET | MIN, 45);
        do_reset(2);
        hold_for(TSET | MIN, 30);
        hold_for(6'b0, 10);
        hold_for(TSET | MIN | HRS | DAY, 40);
        hold_for(MIN | HRS, 30);
        hold_for(ASET | MIN | HRS, 20);
        hold_for(6'b0, 10);
        r = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < 6; b++) if ($urandom_range(0, 11) == 0) r[b] = ~r[b];
            if (k == 700) do_reset(1 + $urandom_range(0, 2));
            tick(r);
        end
        hold_for(6'b0, 2);
        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL leftover_records got %0d expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
